// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte intake and run-time clocks-per-bit.
// Define UART_TX_PARITY_EN to insert a parity bit (8E1/8O1, selected by parity_odd_i).
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | start bit (low) for cpb cycles
// DATA   | eight data bits, LSB first
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); tx_done_o in its final cycle

module uart_tx #(
  parameter int DATA_W = 8,
  parameter int CPB_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [CPB_W-1:0]  clks_per_bit_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_odd_i,
`endif
  output logic              tx_ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              tx_done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [CPB_W-1:0]  cnt;
  logic [CPB_W-1:0]  cpb_m1;
  logic [2:0]        idx;
  logic [DATA_W-1:0] shift;
`ifdef UART_TX_PARITY_EN
  logic              par_bit;
`endif

  logic bit_end;
  logic last_cycle_next;

  assign tx_ready_o = (state == IDLE);
  assign busy_o     = (state != IDLE);
  assign bit_end    = (cnt == cpb_m1);
  // Next cycle is the last of the current bit: lets tx_done_o be a flop.
  assign last_cycle_next = ((cnt + CPB_W'(1)) == cpb_m1);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      cpb_m1    <= '0;
      idx       <= '0;
      shift     <= '0;
      tx_o      <= 1'b1;
      tx_done_o <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      tx_done_o <= 1'b0;
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          cnt  <= '0;
          idx  <= '0;
          if (tx_valid_i) begin
            shift  <= tx_data_i;
            // A zero bit period is treated as one clock per bit.
            cpb_m1 <= (clks_per_bit_i == '0) ? '0 : clks_per_bit_i - CPB_W'(1);
`ifdef UART_TX_PARITY_EN
            par_bit <= (^tx_data_i) ^ parity_odd_i;
`endif
            tx_o   <= 1'b0;
            state  <= START;
          end
        end

        START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            tx_o  <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + CPB_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx_o  <= par_bit;
              state <= PARITY;
`else
              tx_o      <= 1'b1;
              tx_done_o <= (cpb_m1 == '0);
              state     <= STOP;
`endif
            end else begin
              idx   <= idx + 3'd1;
              shift <= shift >> 1;
              tx_o  <= shift[1];
            end
          end else begin
            cnt <= cnt + CPB_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt       <= '0;
            tx_o      <= 1'b1;
            tx_done_o <= (cpb_m1 == '0);
            state     <= STOP;
          end else begin
            cnt <= cnt + CPB_W'(1);
          end
        end
`endif

        STOP: begin
          tx_o <= 1'b1;
          if (bit_end) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt       <= cnt + CPB_W'(1);
            tx_done_o <= last_cycle_next;
          end
        end

        default: begin
          tx_o  <= 1'b1;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
